// File: rtl/counter_updn_mod.sv
// counter_updn_mod: up/down counter over 0..limit with run-time step,
// synchronous load and wrap/saturate mode.
// It produces one-cycle overflow/underflow pulses and zero/limit status.
// Optional macro COUNTER_UPDN_PRESCALE_EN makes only every PRESCALE-th enabled
// cycle a count event.
module counter_updn_mod #(
  parameter int unsigned WIDTH    = 6,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk50m,
  input  logic             rst_n,
  input  logic             en,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] step,
  input  logic             sat,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf,
  output logic             unf,
  output logic             at_zero,
  output logic             at_limit
);

  // One extra bit so that limit+1 and cnt+step never overflow.
  localparam int unsigned AW = WIDTH + 1;

  // Reject an illegal prescale setting at elaboration.
  if ((PRESCALE < 2) || (PRESCALE > 256)) begin : g_bad_prescale
    $error("counter_updn_mod: PRESCALE must be in 2..256");
  end

  logic             count_evt;
  logic [AW-1:0]    cnt_x;
  logic [AW-1:0]    lim_x;
  logic [AW-1:0]    mod_x;
  logic [AW-1:0]    step_x;
  logic [AW-1:0]    s_eff;
  logic [AW-1:0]    sum_x;
  logic [WIDTH-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             unf_nxt;

`ifdef COUNTER_UPDN_PRESCALE_EN
  localparam int unsigned PW = $clog2(PRESCALE);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_nxt;

  // Prescaler: counts enabled cycles, fires on terminal value, cleared by load.
  always_comb begin
    pre_nxt   = pre_q;
    count_evt = 1'b0;
    if (load) begin
      pre_nxt = '0;
    end else if (en) begin
      if (pre_q == PW'(PRESCALE - 1)) begin
        pre_nxt   = '0;
        count_evt = 1'b1;
      end else begin
        pre_nxt = pre_q + PW'(1);
      end
    end
  end

  // Prescaler register.
  always_ff @(posedge clk50m) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= pre_nxt;
  end
`else
  // Without the prescaler every enabled, non-load cycle is a count event.
  assign count_evt = en & ~load;
`endif

  // Widened operands: modulus M = limit+1 and effective step s = min(step, M).
  always_comb begin
    cnt_x  = {1'b0, cnt};
    lim_x  = {1'b0, limit};
    mod_x  = lim_x + AW'(1);
    step_x = {1'b0, step};
    s_eff  = (step_x > mod_x) ? mod_x : step_x;
    sum_x  = cnt_x + s_eff;
  end

  // Next count and pulses: load, out-of-range clamp, then up/down wrap/saturate.
  always_comb begin
    cnt_nxt = cnt;
    ovf_nxt = 1'b0;
    unf_nxt = 1'b0;
    if (load) begin
      cnt_nxt = (load_val > limit) ? limit : load_val;
    end else if (count_evt) begin
      if (cnt_x > lim_x) begin
        cnt_nxt = limit;
      end else if (!down) begin
        if (sum_x <= lim_x) begin
          cnt_nxt = WIDTH'(sum_x);
        end else begin
          ovf_nxt = 1'b1;
          cnt_nxt = sat ? limit : WIDTH'(sum_x - mod_x);
        end
      end else begin
        if (cnt_x >= s_eff) begin
          cnt_nxt = WIDTH'(cnt_x - s_eff);
        end else begin
          unf_nxt = 1'b1;
          cnt_nxt = sat ? '0 : WIDTH'(cnt_x + mod_x - s_eff);
        end
      end
    end
  end

  // Count and pulse registers with synchronous active-low reset.
  always_ff @(posedge clk50m) begin
    if (!rst_n) begin
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
      unf <= unf_nxt;
    end
  end

  // Status flags track the registered count combinationally.
  assign at_zero  = (cnt == '0);
  assign at_limit = (cnt == limit);

endmodule

// File: tb/tb_counter_updn_mod.sv
// Directed self-checking bench for counter_updn_mod (WIDTH=6, PRESCALE=4).
// Defining COUNTER_UPDN_PRESCALE_EN for both files switches to the prescaler scenario.
module tb_counter_updn_mod;

  logic       clk50m = 1'b0;
  logic       rst_n;
  logic       en;
  logic       down;
  logic       load;
  logic [5:0] load_val;
  logic [5:0] limit;
  logic [5:0] step;
  logic       sat;
  logic [5:0] cnt;
  logic       ovf;
  logic       unf;
  logic       at_zero;
  logic       at_limit;

  int checks   = 0;
  int failures = 0;

  counter_updn_mod #(.WIDTH(6), .PRESCALE(4)) dut (
    .clk50m   (clk50m),
    .rst_n    (rst_n),
    .en       (en),
    .down     (down),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .step     (step),
    .sat      (sat),
    .cnt      (cnt),
    .ovf      (ovf),
    .unf      (unf),
    .at_zero  (at_zero),
    .at_limit (at_limit)
  );

  always #10 clk50m = ~clk50m;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 ns later.
  task automatic tick();
    @(posedge clk50m);
    #1;
  endtask

  task automatic do_load(input int lim, input int val);
    limit    = 6'(lim);
    load_val = 6'(val);
    load     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  initial begin
    int exp_up[5];
    int n_ovf;
    int ovf_edge;
    int n_unf;
    exp_up = '{3, 6, 9, 2, 5};

    // Reset dominates load and en.
    rst_n = 1'b0; en = 1'b1; load = 1'b1; load_val = 6'd17;
    limit = 6'd63; step = 6'd1; sat = 1'b0; down = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("rst_cnt", int'(cnt), 0);
      check_val("rst_pulses", int'({ovf, unf}), 0);
      check_val("rst_at_zero", int'(at_zero), 1);
    end
    load = 1'b0;
    rst_n = 1'b1;

`ifdef COUNTER_UPDN_PRESCALE_EN
    // Count event every 4th enabled cycle.
    for (int i = 0; i < 20; i++) tick();
    check_val("pre_20", int'(cnt), 5);
    tick(); tick();
    check_val("pre_hold", int'(cnt), 5);
    do_load(63, 0);
    check_val("pre_load", int'(cnt), 0);
    tick(); tick(); tick();
    check_val("pre_after3", int'(cnt), 0);
    tick();
    check_val("pre_after4", int'(cnt), 1);
`else
    // Natural 6-bit up counter for 100 edges.
    n_ovf = 0; ovf_edge = -1; n_unf = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (ovf) begin n_ovf++; ovf_edge = i; end
      if (unf) n_unf++;
    end
    check_val("up100_cnt", int'(cnt), 36);
    check_val("up100_novf", n_ovf, 1);
    check_val("up100_ovf_edge", ovf_edge, 64);
    check_val("up100_nunf", n_unf, 0);

    // Modulo-10 wrap with step 3, up then down.
    do_load(9, 0);
    check_val("m10_load", int'(cnt), 0);
    step = 6'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("m10_up_cnt", int'(cnt), exp_up[i]);
      check_val("m10_up_ovf", int'(ovf), (i == 3) ? 1 : 0);
    end
    do_load(9, 2);
    check_val("m10_load2", int'(cnt), 2);
    down = 1'b1;
    tick();
    check_val("m10_dn_cnt0", int'(cnt), 9);
    check_val("m10_dn_unf0", int'(unf), 1);
    tick();
    check_val("m10_dn_cnt1", int'(cnt), 6);
    check_val("m10_dn_unf1", int'(unf), 0);

    // Saturating down count sticks at zero.
    step = 6'd4; sat = 1'b1;
    do_load(9, 6);
    check_val("sat_load", int'(cnt), 6);
    tick();
    check_val("sat_cnt0", int'(cnt), 2);
    check_val("sat_unf0", int'(unf), 0);
    tick();
    check_val("sat_cnt1", int'(cnt), 0);
    check_val("sat_unf1", int'(unf), 1);
    check_val("sat_zero1", int'(at_zero), 1);
    tick();
    check_val("sat_cnt2", int'(cnt), 0);
    check_val("sat_unf2", int'(unf), 1);

    // Load clamps to limit; lowering limit clamps without a pulse.
    sat = 1'b0; down = 1'b0; step = 6'd1;
    do_load(40, 50);
    check_val("ld_clamp", int'(cnt), 40);
    check_val("ld_at_limit", int'(at_limit), 1);
    check_val("ld_pulses", int'({ovf, unf}), 0);
    do_load(40, 20);
    check_val("ld_20", int'(cnt), 20);
    do_load(40, 30);
    limit = 6'd10;
    tick();
    check_val("oor_cnt", int'(cnt), 10);
    check_val("oor_ovf", int'(ovf), 0);
    check_val("oor_at_limit", int'(at_limit), 1);

    // Idle hold.
    en = 1'b0;
    tick();
    check_val("idle_cnt", int'(cnt), 10);
    check_val("idle_pulses", int'({ovf, unf}), 0);
    en = 1'b1;

    // Step larger than the range is limited to M: 3 + 10 wraps back to 3.
    step = 6'd20;
    do_load(9, 3);
    tick();
    check_val("bigstep_cnt", int'(cnt), 3);
    check_val("bigstep_ovf", int'(ovf), 1);

    // Degenerate range: limit 0.
    step = 6'd2;
    do_load(0, 5);
    check_val("lim0_load", int'(cnt), 0);
    tick();
    check_val("lim0_up", int'({cnt, ovf, unf}), 2);
    down = 1'b1;
    tick();
    check_val("lim0_dn", int'({cnt, ovf, unf}), 1);

    // Full-width binary wrap down from 0.
    step = 6'd1;
    do_load(63, 0);
    tick();
    check_val("fw_dn_cnt", int'(cnt), 63);
    check_val("fw_dn_unf", int'(unf), 1);
    down = 1'b0;
    tick();
    check_val("fw_up_cnt", int'(cnt), 0);
    check_val("fw_up_ovf", int'(ovf), 1);

    // Saturate up while already at limit still pulses.
    sat = 1'b1;
    do_load(63, 63);
    tick();
    check_val("satup_cnt", int'(cnt), 63);
    check_val("satup_ovf", int'(ovf), 1);

    // Mid-count reset.
    sat = 1'b0;
    do_load(63, 12);
    tick();
    check_val("mid_cnt", int'(cnt), 13);
    rst_n = 1'b0;
    tick();
    check_val("mid_rst_cnt", int'(cnt), 0);
    check_val("mid_rst_pulses", int'({ovf, unf}), 0);
    rst_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
